// File: rtl/lsrt_uart_pkg.sv
// Shared definitions for the uart byte-path blocks: FSM encoding and byte width.
package lsrt_uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_PUSH      = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning last+1, last+2, ...
// modulo NREQ. Reusable by any scheduler that keeps a "last served" index.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] win,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  logic [IDXW-1:0] cand;

  // scan candidates in priority order; the first valid one wins
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDXW'((int'(last) + k) % NREQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_win
    assign win[i] = any && (idx == IDXW'(i));
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one toggle-push uart_tx among NREQ byte sources.
// Each frame: accept -> settle byte -> toggle push -> see tx take it -> see frame end.
// A transmitter that never leaves empty after a push is cleared by a start-timeout.
module uart_tx_arb
  import lsrt_uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TMSB = 7
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     enable,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*BYTE_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic                     timeout,
  input  logic                     tx_empty,
  output logic                     tx_push,
  output logic                     tx_clear,
  output logic [BYTE_W-1:0]        tx_wdata
);

  localparam int IDXW = $clog2(NREQ);
  // timer value one below all-ones: the increment from here "reaches" all-ones
  localparam logic [TMSB:0] T_LAST = {{TMSB{1'b1}}, 1'b0};

  arb_state_e      state, nxt;
  logic [IDXW-1:0] last, win_idx;
  logic [TMSB:0]   timer;

  logic [NREQ-1:0] pick_win;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;
  logic            accept;
  logic            tmo_hit;

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req  (req_valid),
    .last (last),
    .win  (pick_win),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign accept  = enable & tx_empty & pick_any;
  assign tmo_hit = (state == ST_WAIT_BUSY) & tx_empty & (timer == T_LAST);
  assign busy    = (state != ST_IDLE);

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:      if (accept) nxt = ST_LOAD;
      ST_LOAD:      nxt = ST_PUSH;
      ST_PUSH:      nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!tx_empty)    nxt = ST_WAIT_DONE;
        else if (tmo_hit) nxt = ST_IDLE;
      end
      ST_WAIT_DONE: if (tx_empty) nxt = ST_IDLE;
      default:      nxt = ST_IDLE;
    endcase
  end

  // registered outputs and datapath, driven by the current state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_ready <= '0;
      grant     <= '0;
      timeout   <= 1'b0;
      tx_push   <= 1'b0;
      tx_clear  <= 1'b0;
      tx_wdata  <= '0;
      last      <= IDXW'(NREQ - 1);
      win_idx   <= '0;
      timer     <= '0;
    end else begin
      req_ready <= '0;
      timeout   <= 1'b0;
      tx_clear  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            grant     <= pick_win;
            req_ready <= pick_win;
            win_idx   <= pick_idx;
            tx_wdata  <= req_data[pick_idx*BYTE_W +: BYTE_W];
          end
        end
        ST_PUSH: begin
          tx_push <= ~tx_push;
          timer   <= '0;
        end
        ST_WAIT_BUSY: begin
          if (tx_empty) begin
            if (tmo_hit) begin
              // stuck transmitter: drop the byte and clear it, no retry
              tx_clear <= 1'b1;
              timeout  <= 1'b1;
              grant    <= '0;
              last     <= win_idx;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (tx_empty) begin
            grant <= '0;
            last  <= win_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
